// File: rtl/route_distributor_cfg.sv
// Route distributor: maps CHANNEL_NUM channels onto CAPACITOR_NUM lanes under a
// switch mask, with a checked, blanked hand-over when a new mask is requested.
module route_distributor_cfg #(
  parameter int                       WIDTH         = 4,
  parameter int                       CHANNEL_NUM   = 35,
  parameter int                       CAPACITOR_NUM = 40,
  parameter int                       BLANK_CYC     = 4,
  parameter logic [WIDTH-1:0]         IDLE_VAL      = '0,
  parameter logic [CAPACITOR_NUM-1:0] RESET_MASK    = ~({CAPACITOR_NUM{1'b1}} << CHANNEL_NUM)
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [WIDTH*CHANNEL_NUM-1:0]     data_in,
  input  logic [CAPACITOR_NUM-1:0]         sw,
  input  logic                             sw_load,
  output logic                             sw_busy,
  output logic                             sw_err,
  output logic [CAPACITOR_NUM-1:0]         active_mask,
  output logic [WIDTH*CAPACITOR_NUM-1:0]   data_out
);

  localparam int IDX_W = (CHANNEL_NUM > 1) ? $clog2(CHANNEL_NUM) : 1;
  localparam int PC_W  = $clog2(CAPACITOR_NUM + 1);
  localparam int CNT_W = (BLANK_CYC > 2) ? $clog2(BLANK_CYC) : 1;
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'((BLANK_CYC > 0) ? BLANK_CYC - 1 : 0);

  typedef enum logic [1:0] {RUN, CHECK, BLANK, APPLY} state_t;
  typedef logic [CAPACITOR_NUM-1:0][IDX_W-1:0] idx_tbl_t;

  function automatic logic [PC_W-1:0] popcount(input logic [CAPACITOR_NUM-1:0] m);
    logic [PC_W-1:0] n;
    n = '0;
    for (int l = 0; l < CAPACITOR_NUM; l++) n = n + PC_W'(m[l]);
    return n;
  endfunction

  // Entry l is the number of set bits below l, i.e. the channel lane l carries.
  function automatic idx_tbl_t prefix_tbl(input logic [CAPACITOR_NUM-1:0] m);
    idx_tbl_t        tbl;
    logic [PC_W-1:0] run;
    run = '0;
    for (int l = 0; l < CAPACITOR_NUM; l++) begin
      tbl[l] = IDX_W'(run);
      run    = run + PC_W'(m[l]);
    end
    return tbl;
  endfunction

  state_t                   state_q, state_d;
  logic [CAPACITOR_NUM-1:0] mask_q, mask_d;
  logic [CAPACITOR_NUM-1:0] shadow_q, shadow_d;
  logic                     err_q, err_d;
  logic [CNT_W-1:0]         cnt_q, cnt_d;
  idx_tbl_t                 idx_new_q, idx_new_d;
  idx_tbl_t                 idx_live_q, idx_live_d;
  logic [PC_W-1:0]          shadow_pop;
  idx_tbl_t                 shadow_tbl;

  logic [WIDTH-1:0]               din_p1_q [CHANNEL_NUM];
  logic [WIDTH-1:0]               din_p1_d [CHANNEL_NUM];
  logic [WIDTH*CAPACITOR_NUM-1:0] data_out_q, data_out_d;
  logic                           force_idle;

  always_comb begin
    state_d    = state_q;
    mask_d     = mask_q;
    shadow_d   = shadow_q;
    err_d      = err_q;
    cnt_d      = cnt_q;
    idx_new_d  = idx_new_q;
    idx_live_d = idx_live_q;
    shadow_pop = popcount(shadow_q);
    shadow_tbl = prefix_tbl(shadow_q);
    case (state_q)
      RUN: begin
        if (sw_load) begin
          shadow_d = sw;
          state_d  = CHECK;
        end
      end
      CHECK: begin
        idx_new_d = shadow_tbl;
        if (shadow_pop != PC_W'(CHANNEL_NUM)) begin
          err_d   = 1'b1;
          state_d = RUN;
        end else begin
          err_d = 1'b0;
          if (BLANK_CYC == 0) begin
            state_d = APPLY;
          end else begin
            state_d = BLANK;
            cnt_d   = CNT_INIT;
          end
        end
      end
      BLANK: begin
        if (cnt_q == '0) state_d = APPLY;
        else             cnt_d   = cnt_q - CNT_W'(1);
      end
      APPLY: begin
        mask_d     = shadow_q;
        idx_live_d = idx_new_q;
        state_d    = RUN;
      end
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= RUN;
      mask_q     <= RESET_MASK;
      shadow_q   <= RESET_MASK;
      err_q      <= 1'b0;
      cnt_q      <= '0;
      idx_new_q  <= prefix_tbl(RESET_MASK);
      idx_live_q <= prefix_tbl(RESET_MASK);
    end else begin
      state_q    <= state_d;
      mask_q     <= mask_d;
      shadow_q   <= shadow_d;
      err_q      <= err_d;
      cnt_q      <= cnt_d;
      idx_new_q  <= idx_new_d;
      idx_live_q <= idx_live_d;
    end
  end

  // Stage 1: capture the channel inputs
  always_comb begin
    for (int c = 0; c < CHANNEL_NUM; c++) din_p1_d[c] = data_in[WIDTH*c +: WIDTH];
  end

  always_ff @(posedge clk) begin
    din_p1_q <= din_p1_d;
  end

  // Stage 2: per-lane select through the live index table, idled while a new mask is pending
  always_comb begin
    force_idle = (state_q == BLANK) || (state_q == APPLY);
    data_out_d = '0;
    for (int l = 0; l < CAPACITOR_NUM; l++) begin
      data_out_d[WIDTH*l +: WIDTH] = (force_idle || !mask_q[l]) ? IDLE_VAL
                                                                 : din_p1_q[idx_live_q[l]];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) data_out_q <= {CAPACITOR_NUM{IDLE_VAL}};
    else     data_out_q <= data_out_d;
  end

  assign sw_busy     = (state_q != RUN);
  assign sw_err      = err_q;
  assign active_mask = mask_q;
  assign data_out    = data_out_q;

endmodule

// File: tb/tb_route_distributor_cfg.sv
// Scoreboard bench for route_distributor_cfg: one instance with the default
// blanking length and one with zero blanking, sharing clock, reset and data.
`timescale 1ns/1ps
module tb_route_distributor_cfg;
  localparam int W = 4, CH = 35, CAP = 40;
  localparam int DW = W*CH, OW = W*CAP;
  localparam logic [CAP-1:0] RST_M = 40'h07_FFFF_FFFF;
  localparam logic [CAP-1:0] NEW_M = 40'hFF_FFFF_FFE0;

  logic            clk = 1'b0;
  logic            rst;
  logic [DW-1:0]   data_in;
  logic [CAP-1:0]  sw0, sw1, am0, am1;
  logic            ld0, ld1, busy0, busy1, err0, err1;
  logic [OW-1:0]   do0, do1;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [OW-1:0]  d;
    logic           busy;
    logic           err;
    logic [CAP-1:0] m;
  } exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;

  route_distributor_cfg #(.WIDTH(W), .CHANNEL_NUM(CH), .CAPACITOR_NUM(CAP), .BLANK_CYC(4)) dut0 (
    .clk(clk), .rst(rst), .data_in(data_in), .sw(sw0), .sw_load(ld0),
    .sw_busy(busy0), .sw_err(err0), .active_mask(am0), .data_out(do0));

  route_distributor_cfg #(.WIDTH(W), .CHANNEL_NUM(CH), .CAPACITOR_NUM(CAP), .BLANK_CYC(0)) dut1 (
    .clk(clk), .rst(rst), .data_in(data_in), .sw(sw1), .sw_load(ld1),
    .sw_busy(busy1), .sw_err(err1), .active_mask(am1), .data_out(do1));

  // Reference map: walk the mask and hand out channels in order to set bits.
  function automatic logic [OW-1:0] map_exp(input logic [CAP-1:0] m, input logic [DW-1:0] d);
    logic [OW-1:0] r;
    int c;
    r = '0;
    c = 0;
    for (int l = 0; l < CAP; l++) begin
      if (m[l]) begin
        r[W*l +: W] = d[W*c +: W];
        c++;
      end
    end
    return r;
  endfunction

  function automatic logic [DW-1:0] mod16_pattern();
    logic [DW-1:0] d;
    for (int c = 0; c < CH; c++) d[W*c +: W] = W'(c % 16);
    return d;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; ld0 = 1'b0; ld1 = 1'b0; sw0 = '0; sw1 = '0;
    data_in = {DW{1'b1}};
    repeat (5) tick();
    checks++; if (do0 !== '0) begin errors++; $display("FAIL reset_data0 got %h expected 0", do0); end
    checks++; if (am0 !== RST_M) begin errors++; $display("FAIL reset_mask0 got %h expected %h", am0, RST_M); end
    checks++; if (busy0 !== 1'b0) begin errors++; $display("FAIL reset_busy0 got %b expected 0", busy0); end
    checks++; if (err0 !== 1'b0) begin errors++; $display("FAIL reset_err0 got %b expected 0", err0); end
    checks++; if (do1 !== '0) begin errors++; $display("FAIL reset_data1 got %h expected 0", do1); end
    checks++; if (am1 !== RST_M) begin errors++; $display("FAIL reset_mask1 got %h expected %h", am1, RST_M); end
    rst = 1'b0;
  endtask

  task automatic test_map();
    exp_t e;
    logic [OW-1:0] x;
    x = '0;
    for (int l = 0; l < CH; l++) x[W*l +: W] = W'(l % 16);
    data_in = mod16_pattern();
    sb.push_back('{d: x, busy: 1'b0, err: 1'b0, m: RST_M});
    tick(); tick();
    e = sb.pop_front();
    checks++; if (do0 !== e.d) begin errors++; $display("FAIL map_mod16_0 got %h expected %h", do0, e.d); end
    checks++; if (do1 !== e.d) begin errors++; $display("FAIL map_mod16_1 got %h expected %h", do1, e.d); end
  endtask

  task automatic test_back_to_back();
    exp_t e;
    logic [DW-1:0] d;
    for (int i = 0; i < 10; i++) begin
      for (int c = 0; c < CH; c++) d[W*c +: W] = W'($urandom_range(0, 15));
      data_in = d;
      sb.push_back('{d: map_exp(RST_M, d), busy: 1'b0, err: 1'b0, m: RST_M});
      tick();
      if (i >= 1) begin
        e = sb.pop_front();
        checks++; if (do0 !== e.d) begin errors++; $display("FAIL stream_%0d got %h expected %h", i, do0, e.d); end
      end
    end
    tick();
    e = sb.pop_front();
    checks++; if (do0 !== e.d) begin errors++; $display("FAIL stream_last got %h expected %h", do0, e.d); end
  endtask

  task automatic test_reconfig();
    exp_t e;
    logic [DW-1:0] d;
    logic [OW-1:0] shifted;
    int busy_n, idle_n;
    d = mod16_pattern();
    data_in = d;
    tick(); tick();
    shifted = {d, {(5*W){1'b0}}};
    for (int j = 1; j <= 10; j++)
      sb.push_back('{d: (j <= 2) ? map_exp(RST_M, d) : (j <= 7) ? '0 : shifted,
                     busy: (j <= 6), err: 1'b0, m: (j >= 7) ? NEW_M : RST_M});
    busy_n = 0; idle_n = 0;
    sw0 = NEW_M; ld0 = 1'b1;
    for (int j = 1; j <= 10; j++) begin
      tick();
      ld0 = 1'b0;
      e = sb.pop_front();
      if (busy0 === 1'b1) busy_n++;
      if (do0 === '0) idle_n++;
      checks++; if (do0 !== e.d) begin errors++; $display("FAIL reconf_data_j%0d got %h expected %h", j, do0, e.d); end
      checks++; if (busy0 !== e.busy) begin errors++; $display("FAIL reconf_busy_j%0d got %b expected %b", j, busy0, e.busy); end
      checks++; if (am0 !== e.m) begin errors++; $display("FAIL reconf_mask_j%0d got %h expected %h", j, am0, e.m); end
      checks++; if (err0 !== e.err) begin errors++; $display("FAIL reconf_err_j%0d got %b expected %b", j, err0, e.err); end
    end
    checks++; if (busy_n != 6) begin errors++; $display("FAIL reconf_busy_len got %0d expected 6", busy_n); end
    checks++; if (idle_n != 5) begin errors++; $display("FAIL reconf_idle_len got %0d expected 5", idle_n); end
  endtask

  task automatic test_reject();
    exp_t e;
    logic [OW-1:0] x;
    x = {data_in, {(5*W){1'b0}}};
    for (int j = 1; j <= 6; j++)
      sb.push_back('{d: x, busy: (j == 1), err: (j >= 2), m: NEW_M});
    sw0 = 40'h03_FFFF_FFFF; ld0 = 1'b1;
    for (int j = 1; j <= 6; j++) begin
      tick();
      ld0 = 1'b0;
      e = sb.pop_front();
      checks++; if (do0 !== e.d) begin errors++; $display("FAIL reject_data_j%0d got %h expected %h", j, do0, e.d); end
      checks++; if (busy0 !== e.busy) begin errors++; $display("FAIL reject_busy_j%0d got %b expected %b", j, busy0, e.busy); end
      checks++; if (err0 !== e.err) begin errors++; $display("FAIL reject_err_j%0d got %b expected %b", j, err0, e.err); end
      checks++; if (am0 !== e.m) begin errors++; $display("FAIL reject_mask_j%0d got %h expected %h", j, am0, e.m); end
    end
  endtask

  task automatic test_ignore_busy();
    exp_t e;
    logic [OW-1:0] x;
    x = {data_in, {(5*W){1'b0}}};
    for (int j = 1; j <= 11; j++)
      sb.push_back('{d: (j >= 3 && j <= 7) ? '0 : x, busy: (j <= 6), err: (j == 1), m: NEW_M});
    sw0 = NEW_M; ld0 = 1'b1;
    for (int j = 1; j <= 11; j++) begin
      tick();
      ld0 = 1'b0;
      if (j == 3) begin
        sw0 = 40'h03_FFFF_FFFF;
        ld0 = 1'b1;
      end
      e = sb.pop_front();
      checks++; if (do0 !== e.d) begin errors++; $display("FAIL same_mask_data_j%0d got %h expected %h", j, do0, e.d); end
      checks++; if (busy0 !== e.busy) begin errors++; $display("FAIL ignore_busy_j%0d got %b expected %b", j, busy0, e.busy); end
      checks++; if (err0 !== e.err) begin errors++; $display("FAIL ignore_err_j%0d got %b expected %b", j, err0, e.err); end
      checks++; if (am0 !== e.m) begin errors++; $display("FAIL ignore_mask_j%0d got %h expected %h", j, am0, e.m); end
    end
  endtask

  task automatic test_abort();
    sw0 = 40'h7F_FFFF_FFF0; ld0 = 1'b1;
    tick();
    ld0 = 1'b0;
    tick(); tick();
    checks++; if (busy0 !== 1'b1) begin errors++; $display("FAIL abort_pre_busy got %b expected 1", busy0); end
    rst = 1'b1; ld0 = 1'b1;
    tick();
    checks++; if (am0 !== RST_M) begin errors++; $display("FAIL abort_mask got %h expected %h", am0, RST_M); end
    checks++; if (busy0 !== 1'b0) begin errors++; $display("FAIL abort_busy got %b expected 0", busy0); end
    checks++; if (err0 !== 1'b0) begin errors++; $display("FAIL abort_err got %b expected 0", err0); end
    checks++; if (do0 !== '0) begin errors++; $display("FAIL abort_data got %h expected 0", do0); end
    tick();
    checks++; if (busy0 !== 1'b0) begin errors++; $display("FAIL rst_vs_load_busy got %b expected 0", busy0); end
    rst = 1'b0; ld0 = 1'b0;
    tick(); tick();
    checks++; if (busy0 !== 1'b0) begin errors++; $display("FAIL post_abort_busy got %b expected 0", busy0); end
    checks++; if (am0 !== RST_M) begin errors++; $display("FAIL post_abort_mask got %h expected %h", am0, RST_M); end
  endtask

  task automatic test_zero_blank();
    exp_t e;
    logic [DW-1:0]  d;
    logic [CAP-1:0] m6;
    int idle_n;
    m6 = 40'hAA_AAAA_AAAA;
    for (int b = 10; b <= 38; b += 2) m6[b] = 1'b1;
    for (int c = 0; c < CH; c++) d[W*c +: W] = W'((c*7 + 3) % 16);
    data_in = d;
    tick(); tick();
    for (int j = 1; j <= 6; j++)
      sb.push_back('{d: (j <= 2) ? map_exp(RST_M, d) : (j == 3) ? '0 : map_exp(m6, d),
                     busy: (j <= 2), err: 1'b0, m: (j >= 3) ? m6 : RST_M});
    idle_n = 0;
    sw1 = m6; ld1 = 1'b1;
    for (int j = 1; j <= 6; j++) begin
      tick();
      ld1 = 1'b0;
      e = sb.pop_front();
      if (do1 === '0) idle_n++;
      checks++; if (do1 !== e.d) begin errors++; $display("FAIL zb_data_j%0d got %h expected %h", j, do1, e.d); end
      checks++; if (busy1 !== e.busy) begin errors++; $display("FAIL zb_busy_j%0d got %b expected %b", j, busy1, e.busy); end
      checks++; if (am1 !== e.m) begin errors++; $display("FAIL zb_mask_j%0d got %h expected %h", j, am1, e.m); end
      checks++; if (err1 !== e.err) begin errors++; $display("FAIL zb_err_j%0d got %b expected %b", j, err1, e.err); end
    end
    checks++; if (idle_n != 1) begin errors++; $display("FAIL zb_idle_len got %0d expected 1", idle_n); end
  endtask

  initial begin
    test_reset();
    test_map();
    test_back_to_back();
    test_reconfig();
    test_reject();
    test_ignore_busy();
    test_abort();
    test_zero_blank();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
